// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage control/data bundle between hazard unit, imem and the fetch stage.
// FETCH_COUNT_EN adds the o_fetch_count observation port.
interface fetch_stage_ctrl_if;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic        i_halt;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic [31:0] i_imem_data;
  logic [31:0] o_imem_addr;
  logic [31:0] o_if_id_instr;
  logic [31:0] o_if_id_pc_plus4;
  logic        o_if_id_valid;
  logic        o_halted;
`ifdef FETCH_COUNT_EN
  logic [31:0] o_fetch_count;
`endif

  modport master (
    output i_enable, i_stall, i_flush, i_halt, i_redirect_valid, i_redirect_pc, i_imem_data,
    input  o_imem_addr, o_if_id_instr, o_if_id_pc_plus4, o_if_id_valid, o_halted
`ifdef FETCH_COUNT_EN
    , input o_fetch_count
`endif
  );

  modport slave (
    input  i_enable, i_stall, i_flush, i_halt, i_redirect_valid, i_redirect_pc, i_imem_data,
    output o_imem_addr, o_if_id_instr, o_if_id_pc_plus4, o_if_id_valid, o_halted
`ifdef FETCH_COUNT_EN
    , output o_fetch_count
`endif
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: PC, imem addressing, IF/ID register and halt/drain sequencer.
// Optional FETCH_COUNT_EN adds a 32-bit count of valid IF/ID loads.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fetch_stage_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [31:0]       fcnt_q, fcnt_d;
  logic [31:0]       pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fcnt_d   = fcnt_q;
    if (bus.i_enable) begin
      // halted is a registered copy of the HALTED state, so it lags entry by one cycle
      halted_d = halted_q | (state_q == HALTED);
      unique case (state_q)
        RUN: begin
          if (bus.i_flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = bus.i_redirect_valid ? bus.i_redirect_pc : pc_plus4;
          end else if (bus.i_stall) begin
            pc_d = pc_q;
          end else if (bus.i_halt) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            instr_d = bus.i_imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = bus.i_redirect_valid ? bus.i_redirect_pc : pc_plus4;
            fcnt_d  = fcnt_q + 32'd1;
          end
        end
        DRAIN: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = HALTED;
        end
        default: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.o_imem_addr      = pc_q;
  assign bus.o_if_id_instr    = instr_q;
  assign bus.o_if_id_pc_plus4 = pc4_q;
  assign bus.o_if_id_valid    = valid_q;
  assign bus.o_halted         = halted_q;
`ifdef FETCH_COUNT_EN
  assign bus.o_fetch_count    = fcnt_q;
`else
  logic unused_fcnt;
  assign unused_fcnt = ^fcnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: fetch, stall, flush/redirect, halt drain, reset, wrap.
module tb_fetch_stage_ctrl;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int asserts = 0;
  int fails = 0;

  fetch_stage_ctrl_if bus();

  fetch_stage_ctrl dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2001_0005;
      32'h4:   return 32'h2002_0007;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign bus.i_imem_data = imem(bus.o_imem_addr);

  task automatic step;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs;
    bus.i_enable = 1'b1; bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_halt = 1'b0;
    bus.i_redirect_valid = 1'b0; bus.i_redirect_pc = 32'h0;
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, bus.o_halted}
        !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state got addr=%h instr=%h pc4=%h v=%b h=%b exp 0/0/0/0/0",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, bus.o_halted);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    asserts++;
    if (bus.o_imem_addr !== 32'h0) begin fails++; $display("FAIL fetch_c0_addr got %h exp 0", bus.o_imem_addr); end
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
      fails++; $display("FAIL fetch_c1 got addr=%h instr=%h pc4=%h v=%b exp 4/20010005/4/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid);
    end
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
      fails++; $display("FAIL fetch_c2 got addr=%h instr=%h pc4=%h v=%b exp 8/20020007/8/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid);
    end
  endtask

  task automatic test_stall;
    bus.i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      asserts++;
      if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h8, 32'h2002_0007, 32'h8, 1'b1}) begin
        fails++; $display("FAIL stall_hold%0d got addr=%h instr=%h v=%b exp 8/20020007/1",
          i, bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid);
      end
    end
    bus.i_stall = 1'b0;
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'hC, imem(32'h8), 32'hC, 1'b1}) begin
      fails++; $display("FAIL stall_resume got addr=%h instr=%h pc4=%h v=%b exp c/%h/c/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, imem(32'h8));
    end
    step();
  endtask

  task automatic test_flush;
    asserts++;
    if (bus.o_imem_addr !== 32'h10) begin fails++; $display("FAIL flush_pre_addr got %h exp 10", bus.o_imem_addr); end
    bus.i_flush = 1'b1; bus.i_redirect_valid = 1'b1; bus.i_redirect_pc = 32'h40;
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid} !== {32'h40, 32'h0, 1'b0}) begin
      fails++; $display("FAIL flush_bubble got addr=%h instr=%h v=%b exp 40/0/0",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid);
    end
    idle_inputs();
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h44, imem(32'h40), 32'h44, 1'b1}) begin
      fails++; $display("FAIL flush_target_fetch got addr=%h instr=%h pc4=%h v=%b exp 44/%h/44/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, imem(32'h40));
    end
  endtask

  task automatic test_halt_flush;
    bus.i_halt = 1'b1; bus.i_flush = 1'b1;
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_valid} !== {32'h48, 1'b0}) begin
      fails++; $display("FAIL halt_flush_bubble got addr=%h v=%b exp 48/0", bus.o_imem_addr, bus.o_if_id_valid);
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      step();
      asserts++;
      if (bus.o_halted !== 1'b0) begin fails++; $display("FAIL halt_flush_no_halt%0d got %b exp 0", i, bus.o_halted); end
    end
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_valid} !== {32'h60, 1'b1}) begin
      fails++; $display("FAIL halt_flush_run got addr=%h v=%b exp 60/1", bus.o_imem_addr, bus.o_if_id_valid);
    end
  endtask

  task automatic test_enable_freeze;
    bus.i_enable = 1'b0; bus.i_halt = 1'b1;
    step(); step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid, bus.o_halted} !== {32'h60, imem(32'h5C), 1'b1, 1'b0}) begin
      fails++; $display("FAIL enable_freeze got addr=%h instr=%h v=%b h=%b exp 60/%h/1/0",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid, bus.o_halted, imem(32'h5C));
    end
    idle_inputs();
  endtask

  task automatic test_redirect_wrap;
    bus.i_redirect_valid = 1'b1; bus.i_redirect_pc = 32'h200;
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h200, imem(32'h60), 32'h64, 1'b1}) begin
      fails++; $display("FAIL redirect_noflush got addr=%h instr=%h pc4=%h v=%b exp 200/%h/64/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, imem(32'h60));
    end
    bus.i_flush = 1'b1; bus.i_redirect_pc = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid} !== {32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1}) begin
      fails++; $display("FAIL pc_wrap got addr=%h instr=%h pc4=%h v=%b exp 0/%h/0/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_pc_plus4, bus.o_if_id_valid, imem(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_halt;
    bus.i_flush = 1'b1; bus.i_redirect_valid = 1'b1; bus.i_redirect_pc = 32'h14;
    step();
    idle_inputs();
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      asserts++;
      if ({bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted} !== {32'h14, 1'b0, 1'b0}) begin
        fails++; $display("FAIL halt_drain%0d got addr=%h v=%b h=%b exp 14/0/0",
          i, bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted);
      end
      if (i == 2) begin bus.i_flush = 1'b1; bus.i_stall = 1'b1; bus.i_redirect_valid = 1'b1; bus.i_redirect_pc = 32'h100; end
      step();
    end
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted} !== {32'h14, 1'b0, 1'b1}) begin
      fails++; $display("FAIL halt_done got addr=%h v=%b h=%b exp 14/0/1", bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted);
    end
    step(); step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_halted} !== {32'h14, 1'b1}) begin
      fails++; $display("FAIL halt_sticky got addr=%h h=%b exp 14/1", bus.o_imem_addr, bus.o_halted);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    step(); step();
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    step();
    #2 i_rst_n = 1'b0;
    #1;
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted} !== {32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_mid_drain got addr=%h v=%b h=%b exp 0/0/0", bus.o_imem_addr, bus.o_if_id_valid, bus.o_halted);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid} !== {32'h4, 32'h2001_0005, 1'b1}) begin
      fails++; $display("FAIL post_reset_fetch got addr=%h instr=%h v=%b exp 4/20010005/1",
        bus.o_imem_addr, bus.o_if_id_instr, bus.o_if_id_valid);
    end
  endtask

  task automatic test_drain_pause;
    bus.i_halt = 1'b1;
    step();
    bus.i_halt = 1'b0;
    bus.i_enable = 1'b0;
    step(); step(); step();
    bus.i_enable = 1'b1;
    step(); step(); step(); step();
    asserts++;
    if ({bus.o_imem_addr, bus.o_halted} !== {32'h4, 1'b0}) begin
      fails++; $display("FAIL drain_pause_early got addr=%h h=%b exp 4/0", bus.o_imem_addr, bus.o_halted);
    end
    step();
    asserts++;
    if (bus.o_halted !== 1'b1) begin fails++; $display("FAIL drain_pause_done got %b exp 1", bus.o_halted); end
  endtask

`ifdef FETCH_COUNT_EN
  task automatic test_fetch_count;
    do_reset();
    asserts++;
    if (bus.o_fetch_count !== 32'd0) begin fails++; $display("FAIL fcnt_reset got %0d exp 0", bus.o_fetch_count); end
    for (int i = 0; i < 10; i++) step();
    bus.i_stall = 1'b1; step(); step();
    bus.i_stall = 1'b0; bus.i_flush = 1'b1; step();
    bus.i_flush = 1'b0; bus.i_enable = 1'b0; step(); step(); step();
    asserts++;
    if (bus.o_fetch_count !== 32'd10) begin fails++; $display("FAIL fcnt_mix got %0d exp 10", bus.o_fetch_count); end
    idle_inputs();
    bus.i_halt = 1'b1; step();
    bus.i_halt = 1'b0;
    for (int i = 0; i < 7; i++) step();
    asserts++;
    if (bus.o_fetch_count !== 32'd10) begin fails++; $display("FAIL fcnt_halt got %0d exp 10", bus.o_fetch_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_halt_flush();
    test_enable_freeze();
    test_redirect_wrap();
    test_halt();
    test_reset_mid_drain();
    test_drain_pause();
`ifdef FETCH_COUNT_EN
    test_fetch_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
